// File: rtl/sdram_page_sched.sv
`default_nettype none
// ============================================================================
// Module   : sdram_page_sched
// Purpose  : Page-level scheduler in front of the SDRAM page controller.
//            Treats the SDRAM region as a circular buffer of pages. It
//            issues full-page writes from the inbound FIFO and full-page
//            reads into the outbound FIFO. When both directions are
//            eligible it arbitrates round-robin.
// Ports    : clk, reset_n            - clock, async active-low reset
//            enable, clear           - host control (sampled in S_IDLE)
//            wr_level, rd_space      - inbound FIFO fill / outbound FIFO room
//            cmd_pagewrite/pageread  - registered page requests
//            rowaddr                 - row of the current request
//            cmd_ack, cmd_done       - controller handshake pulses
//            pages_used, full, empty - buffer fill state (registered)
//            busy                    - scheduler not idle
//            pages_written/read      - statistics counters
// Config   : define SDRAM_SCHED_STATS_EN to build the statistics counters.
//            When it is undefined, both statistics outputs read 0.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_page_sched #(
    parameter int          PAGE_WORDS = 512,
    parameter logic [14:0] BASE_ROW   = 15'd0,
    parameter logic [15:0] NUM_PAGES  = 16'd32768
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear,
    input  logic [10:0] wr_level,
    input  logic [10:0] rd_space,
    output logic        cmd_pagewrite,
    output logic        cmd_pageread,
    output logic [14:0] rowaddr,
    input  logic        cmd_ack,
    input  logic        cmd_done,
    output logic [15:0] pages_used,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic [31:0] pages_written,
    output logic [31:0] pages_read
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT   = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    localparam logic [10:0] c_page_words = 11'(PAGE_WORDS);
    localparam logic [15:0] c_last_page  = NUM_PAGES - 16'd1;
    localparam logic        c_op_read    = 1'b0;
    localparam logic        c_op_write   = 1'b1;

    state_t      r_state,   w_state;
    logic [14:0] r_wr_ptr,  w_wr_ptr;
    logic [14:0] r_rd_ptr,  w_rd_ptr;
    logic [15:0] r_used,    w_used;
    logic        r_full,    w_full;
    logic        r_empty,   w_empty;
    logic        r_busy,    w_busy;
    logic        r_last_op, w_last_op;
    logic        r_pw,      w_pw;
    logic        r_pr,      w_pr;
    logic [14:0] r_row,     w_row;
    logic        r_wr_elig, w_wr_elig;
    logic        r_rd_elig, w_rd_elig;
    logic        w_idle_clear;
    logic        w_grant_wr;
    logic        w_grant_rd;
    logic        w_done_wr;
    logic        w_done_rd;

    function automatic logic [14:0] f_next_ptr(input logic [14:0] p);
        return ({1'b0, p} == c_last_page) ? 15'd0 : p + 15'd1;
    endfunction

    // Eligibility is registered, so a grant in S_IDLE uses flags sampled one
    // edge earlier. S_SETTLE exists so that, after a transfer, this sample
    // sees the updated FIFO levels and the updated full/empty flags.
    // A clear in progress masks the sample. Otherwise a stale flag could
    // grant a read from a buffer that was just emptied.
    assign w_idle_clear = (r_state == S_IDLE) && clear;
    assign w_wr_elig = enable && !r_full  && (wr_level >= c_page_words) && !w_idle_clear;
    assign w_rd_elig = enable && !r_empty && (rd_space >= c_page_words) && !w_idle_clear;

    // Live enable also gates the grant, so that dropping enable takes effect
    // without an extra cycle of lag.
    assign w_grant_wr = r_wr_elig && enable && (!r_rd_elig || (r_last_op == c_op_read));
    assign w_grant_rd = r_rd_elig && enable && !w_grant_wr;

    assign w_done_wr = (r_state == S_WAIT) && cmd_done && (r_last_op == c_op_write);
    assign w_done_rd = (r_state == S_WAIT) && cmd_done && (r_last_op == c_op_read);

    always_comb begin
        w_state   = r_state;
        w_wr_ptr  = r_wr_ptr;
        w_rd_ptr  = r_rd_ptr;
        w_used    = r_used;
        w_last_op = r_last_op;
        w_pw      = r_pw;
        w_pr      = r_pr;
        w_row     = r_row;
        case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_wr_ptr = 15'd0;
                    w_rd_ptr = 15'd0;
                    w_used   = 16'd0;
                end else if (w_grant_wr) begin
                    w_pw      = 1'b1;
                    w_row     = BASE_ROW + r_wr_ptr;
                    w_last_op = c_op_write;
                    w_state   = S_REQ;
                end else if (w_grant_rd) begin
                    w_pr      = 1'b1;
                    w_row     = BASE_ROW + r_rd_ptr;
                    w_last_op = c_op_read;
                    w_state   = S_REQ;
                end
            end
            S_REQ: begin
                if (cmd_ack) begin
                    w_pw    = 1'b0;
                    w_pr    = 1'b0;
                    w_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cmd_done) begin
                    w_state = S_SETTLE;
                    if (r_last_op == c_op_write) begin
                        w_wr_ptr = f_next_ptr(r_wr_ptr);
                        w_used   = r_used + 16'd1;
                    end else begin
                        w_rd_ptr = f_next_ptr(r_rd_ptr);
                        w_used   = r_used - 16'd1;
                    end
                end
            end
            S_SETTLE: w_state = S_IDLE;
            default:  w_state = S_IDLE;
        endcase
        w_full  = (w_used == NUM_PAGES);
        w_empty = (w_used == 16'd0);
        w_busy  = (w_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= 15'd0;
            r_rd_ptr  <= 15'd0;
            r_used    <= 16'd0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_busy    <= 1'b0;
            r_last_op <= c_op_read;
            r_pw      <= 1'b0;
            r_pr      <= 1'b0;
            r_row     <= BASE_ROW;
            r_wr_elig <= 1'b0;
            r_rd_elig <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_wr_ptr  <= w_wr_ptr;
            r_rd_ptr  <= w_rd_ptr;
            r_used    <= w_used;
            r_full    <= w_full;
            r_empty   <= w_empty;
            r_busy    <= w_busy;
            r_last_op <= w_last_op;
            r_pw      <= w_pw;
            r_pr      <= w_pr;
            r_row     <= w_row;
            r_wr_elig <= w_wr_elig;
            r_rd_elig <= w_rd_elig;
        end
    end

`ifdef SDRAM_SCHED_STATS_EN
    logic [31:0] r_pages_written;
    logic [31:0] r_pages_read;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pages_written <= 32'd0;
            r_pages_read    <= 32'd0;
        end else if (w_idle_clear) begin
            r_pages_written <= 32'd0;
            r_pages_read    <= 32'd0;
        end else begin
            if (w_done_wr) r_pages_written <= r_pages_written + 32'd1;
            if (w_done_rd) r_pages_read    <= r_pages_read + 32'd1;
        end
    end

    assign pages_written = r_pages_written;
    assign pages_read    = r_pages_read;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_done_wr ^ w_done_rd;
    assign pages_written  = 32'd0;
    assign pages_read     = 32'd0;
`endif

    assign cmd_pagewrite = r_pw;
    assign cmd_pageread  = r_pr;
    assign rowaddr       = r_row;
    assign pages_used    = r_used;
    assign full          = r_full;
    assign empty         = r_empty;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sdram_page_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_page_sched
// Purpose  : Self-checking bench for sdram_page_sched. The bench drives a
//            4-page buffer at row 100. A queue holds the expected request
//            sequence; the controller model pops and compares each request
//            as it appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_page_sched;

`ifdef SDRAM_SCHED_STATS_EN
    localparam bit c_stats = 1'b1;
`else
    localparam bit c_stats = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        clear;
    logic [10:0] wr_level;
    logic [10:0] rd_space;
    logic        cmd_pagewrite;
    logic        cmd_pageread;
    logic [14:0] rowaddr;
    logic        cmd_ack;
    logic        cmd_done;
    logic [15:0] pages_used;
    logic        full;
    logic        empty;
    logic        busy;
    logic [31:0] pages_written;
    logic [31:0] pages_read;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];   // {is_write, row}

    sdram_page_sched #(
        .PAGE_WORDS (512),
        .BASE_ROW   (15'd100),
        .NUM_PAGES  (16'd4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .clear         (clear),
        .wr_level      (wr_level),
        .rd_space      (rd_space),
        .cmd_pagewrite (cmd_pagewrite),
        .cmd_pageread  (cmd_pageread),
        .rowaddr       (rowaddr),
        .cmd_ack       (cmd_ack),
        .cmd_done      (cmd_done),
        .pages_used    (pages_used),
        .full          (full),
        .empty         (empty),
        .busy          (busy),
        .pages_written (pages_written),
        .pages_read    (pages_read)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for a request, compares it against the scoreboard, holds it for
    // ack_delay cycles, then acks. edges = edges from the previous done edge.
    task automatic start_op(input int ack_delay, output int edges);
        int cnt;
        int hi;
        logic [15:0] exp;
        cnt = 0;
        while (!(cmd_pagewrite || cmd_pageread) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        edges = cnt + 1;
        if (!(cmd_pagewrite || cmd_pageread)) begin
            check("req_timeout", 32'd0, 32'd1);
            return;
        end
        check("req_onehot", {31'd0, cmd_pagewrite & cmd_pageread}, 32'd0);
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
            exp = 16'hffff;
        end else begin
            exp = sb.pop_front();
        end
        check("req", {16'd0, cmd_pagewrite, rowaddr}, {16'd0, exp});
        hi = 0;
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            if (cmd_pagewrite || cmd_pageread) hi++;
        end
        check("req_hold", hi, ack_delay);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        check("req_drop", {31'd0, cmd_pagewrite | cmd_pageread}, 32'd0);
        check("busy_wait", {31'd0, busy}, 32'd1);
    endtask

    task automatic finish_op(input int done_delay);
        repeat (done_delay) @(negedge clk);
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
    endtask

    initial begin
        int e;
        int hi;
        reset_n  = 1'b0;
        enable   = 1'b0;
        clear    = 1'b0;
        wr_level = 11'd0;
        rd_space = 11'd0;
        cmd_ack  = 1'b0;
        cmd_done = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_pw",    {31'd0, cmd_pagewrite}, 32'd0);
        check("rst_pr",    {31'd0, cmd_pageread},  32'd0);
        check("rst_row",   {17'd0, rowaddr},       32'd100);
        check("rst_used",  {16'd0, pages_used},    32'd0);
        check("rst_empty", {31'd0, empty},         32'd1);
        check("rst_full",  {31'd0, full},          32'd0);
        check("rst_busy",  {31'd0, busy},          32'd0);
        check("rst_stw",   pages_written,          32'd0);
        check("rst_str",   pages_read,             32'd0);

        reset_n = 1'b1;
        @(negedge clk);
        enable   = 1'b1;
        wr_level = 11'd512;
        sb.push_back({1'b1, 15'd100});
        @(negedge clk);
        check("lat_edge1", {31'd0, cmd_pagewrite}, 32'd0);
        @(negedge clk);
        check("lat_edge2", {31'd0, cmd_pagewrite}, 32'd1);
        start_op(3, e);
        finish_op(600);
        check("used_1",  {16'd0, pages_used}, 32'd1);
        check("empty_0", {31'd0, empty},      32'd0);

        // Fill the remaining three pages.
        for (int i = 1; i < 4; i++) begin
            sb.push_back({1'b1, 15'(100 + i)});
            start_op(2, e);
            finish_op(10);
            check("used_fill", {16'd0, pages_used}, i + 1);
        end
        check("full_1", {31'd0, full}, 32'd1);
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_pagewrite) hi++;
        end
        check("no_write_when_full", hi, 32'd0);
        check("idle_when_full", {31'd0, busy}, 32'd0);

        // Only a read is eligible now: it takes the oldest page.
        rd_space = 11'd512;
        sb.push_back({1'b0, 15'd100});
        start_op(1, e);
        finish_op(5);
        check("full_0",  {31'd0, full},        32'd0);
        check("used_3",  {16'd0, pages_used},  32'd3);

        // Both directions eligible: W, R, W, R with minimum turnaround.
        sb.push_back({1'b1, 15'd100});
        sb.push_back({1'b0, 15'd101});
        sb.push_back({1'b1, 15'd101});
        sb.push_back({1'b0, 15'd102});
        for (int i = 0; i < 4; i++) begin
            start_op(1, e);
            check("turnaround", e, 32'd3);
            finish_op(5);
        end
        check("used_alt", {16'd0, pages_used}, 32'd3);

        // Controller holds off its ack for 20 cycles.
        sb.push_back({1'b1, 15'd102});
        start_op(20, e);
        check("turnaround_slow", e, 32'd3);
        finish_op(5);
        check("used_4", {16'd0, pages_used}, 32'd4);

        // clear pulsed during S_WAIT must be ignored.
        sb.push_back({1'b0, 15'd103});
        start_op(1, e);
        clear = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        wr_level = 11'd0;
        rd_space = 11'd0;
        finish_op(5);
        check("clear_in_wait", {16'd0, pages_used}, 32'd3);
        check("stat_wr", pages_written, c_stats ? 32'd7 : 32'd0);
        check("stat_rd", pages_read,    c_stats ? 32'd4 : 32'd0);

        // clear held in S_IDLE empties the buffer.
        repeat (2) @(negedge clk);
        clear = 1'b1;
        repeat (3) @(negedge clk);
        check("clear_used",  {16'd0, pages_used}, 32'd0);
        check("clear_empty", {31'd0, empty},      32'd1);
        check("clear_stw",   pages_written,       32'd0);
        check("clear_str",   pages_read,          32'd0);
        clear    = 1'b0;
        wr_level = 11'd512;
        sb.push_back({1'b1, 15'd100});
        start_op(1, e);
        finish_op(5);
        check("post_clear_used", {16'd0, pages_used}, 32'd1);

        // Reset in the middle of a transfer.
        sb.push_back({1'b1, 15'd101});
        start_op(1, e);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy",  {31'd0, busy},          32'd0);
        check("arst_pw",    {31'd0, cmd_pagewrite}, 32'd0);
        check("arst_row",   {17'd0, rowaddr},       32'd100);
        check("arst_used",  {16'd0, pages_used},    32'd0);
        check("arst_empty", {31'd0, empty},         32'd1);
        wr_level = 11'd0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_done_busy", {31'd0, busy},          32'd0);
        check("stray_done_used", {16'd0, pages_used},    32'd0);
        check("stray_done_req",  {31'd0, cmd_pagewrite | cmd_pageread}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_page_sched.md
# sdram_page_sched

Page-level scheduler that sits in front of the SDRAM page controller and decides when to issue full-page writes and reads. It manages the SDRAM as a circular buffer of 512-word pages, fed by an inbound host FIFO and drained into an outbound host FIFO. It tracks write/read page pointers and fill level, and arbitrates round-robin when both directions are eligible. It drives the controller's `cmd_pagewrite`/`cmd_pageread`/`rowaddr_in` and consumes its `cmd_ack`/`cmd_done` pulses.

## Interface
- PAGE_WORDS, 512: words per page; eligibility threshold for both FIFOs.
- BASE_ROW, 15'd0: first row (bank+row) of the buffer region.
- NUM_PAGES, 16'd32768: pages in the region; 1..32768.
- clk  in  1  system clock, same as the SDRAM controller.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, no new operation starts; an in-flight operation completes.
- clear  in  1  empties the buffer: pointers and count to 0. Honoured in S_IDLE only.
- wr_level  in  11  words currently in the inbound FIFO.
- rd_space  in  11  free words in the outbound FIFO.
- cmd_pagewrite  out  1  page-write request to the controller.
- cmd_pageread  out  1  page-read request to the controller.
- rowaddr  out  15  row for the current request; stable from request to done.
- cmd_ack  in  1  one-cycle pulse: controller accepted the request.
- cmd_done  in  1  one-cycle pulse: page transfer finished.
- pages_used  out  16  pages written and not yet read.
- full  out  1  pages_used == NUM_PAGES.
- empty  out  1  pages_used == 0.
- busy  out  1  state != S_IDLE.
- pages_written  out  32  statistics; see Configuration.
- pages_read  out  32  statistics; see Configuration.

## Operation
- States:
  - S_IDLE: evaluate eligibility.
  - S_REQ: hold the request until `cmd_ack`.
  - S_WAIT: wait for `cmd_done`.
  - S_SETTLE: one cycle, lets FIFO level flags update.
- Write eligible: `enable & !full & wr_level >= PAGE_WORDS`.
- Read eligible: `enable & !empty & rd_space >= PAGE_WORDS`.
- Arbitration: if only one direction is eligible, it wins. If both are, pick the opposite of `last_op`.
- `last_op` resets to READ, so the first contested grant is a write.
- In S_IDLE, if `clear`=1: set wr_ptr, rd_ptr and pages_used to 0 and stay in S_IDLE. `clear` takes priority over any grant.
- On grant:
  - Register the request bit and `rowaddr = BASE_ROW + ptr` (mod 2^15).
  - Set `last_op`.
  - Go to S_REQ.
- S_REQ: keep the request high. On the edge sampling `cmd_ack`=1, drop the request and go to S_WAIT.
- S_WAIT: on `cmd_done`=1, go to S_SETTLE and update state:
  - Write: wr_ptr advances, pages_used +1.
  - Read: rd_ptr advances, pages_used −1.
  - Pointer advance wraps NUM_PAGES−1 → 0.
- S_SETTLE: go to S_IDLE unconditionally.
- `rowaddr` holds its value outside S_REQ/S_WAIT.
- Never more than one operation is outstanding, so count increment and decrement cannot coincide.
- `clear` and `enable` are ignored outside S_IDLE; they must be held by the host.
- `cmd_done` seen outside S_WAIT is ignored. `cmd_ack` seen outside S_REQ is ignored.

## Timing
- Reset values:
  - cmd_pagewrite = 0, cmd_pageread = 0, rowaddr = BASE_ROW.
  - pages_used = 0, empty = 1, full = 0, busy = 0.
  - pages_written = 0, pages_read = 0.
  - state = S_IDLE, last_op = READ.
- Latency:
  - Eligibility in S_IDLE at edge N → request high after edge N+1.
  - Request is low after the edge that samples `cmd_ack`.
- Turnaround: from the `cmd_done` edge to the earliest next request is 3 edges (S_SETTLE, S_IDLE, S_REQ).
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-operation: everything returns to reset values immediately. Buffer contents are discarded. The SDRAM controller must be reset in the same event.
- `full`/`empty` are registered and update together with `pages_used`.

## Configuration
- `SDRAM_SCHED_STATS_EN` defined:
  - `pages_written`/`pages_read` are 32-bit counters.
  - They increment on each write/read `cmd_done` in S_WAIT and wrap at 2^32.
  - `clear` also zeroes them.
- Not defined: both outputs are tied to 0 and no counter registers exist.

## Test plan
- Reset, wr_level=512, rd_space=0 → cmd_pagewrite rises 2 edges later with rowaddr=BASE_ROW. Ack after 3 cycles, done after 600 → pages_used=1, empty=0, wr_ptr=1.
- Both eligible continuously (wr_level=2047, rd_space=2047, after one page written) → grants alternate W,R,W,R. Each request has the 3-edge turnaround after done.
- NUM_PAGES=4, BASE_ROW=100, write 4 pages, rd_space=0 → rows 100–103 issued, then full=1 and no further write. A read then issues row 100, full=0, and the next write targets row 100.
- Controller delays `cmd_ack` 20 cycles (refresh) → request stays high for exactly those cycles, then drops one edge after ack. No duplicate operation.
- `clear` pulsed during S_WAIT → ignored. `clear` held into S_IDLE → pages_used=0, empty=1, next write uses BASE_ROW. With `SDRAM_SCHED_STATS_EN`, stats also read 0.
- reset_n low mid-S_WAIT → all outputs at reset values asynchronously. A stray `cmd_done` after release is ignored.
